// File: rtl/croc_lane.sv
// croc_lane: one crocodile sprite on a Frogger river lane.
// Renders per-pixel body/jaw coverage from hc/vc and advances position and jaw once per frame tick.
module croc_lane #(
  parameter int LANE_Y          = 200,
  parameter int CROC_W          = 96,
  parameter int CROC_H          = 32,
  parameter int HEAD_W          = 32,
  parameter int H_START         = 144,
  parameter int H_ACTIVE        = 640,
  parameter int FRAME_LINE      = 515,
  parameter int SPEED           = 2,
  parameter int FRAME_DIV       = 1,
  parameter int DIR             = 0,
  parameter int START_X         = 0,
  parameter int MOUTH_CLOSED_FR = 60,
  parameter int MOUTH_OPEN_FR   = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hc,
  input  logic [9:0] vc,
  input  logic       pause,
  output logic       croc,
  output logic       croc_jaw,
  output logic [9:0] croc_x,
  output logic       mouth_open
);

  // state  | meaning
  // CLOSED | jaw shut, counting MOUTH_CLOSED_FR frames
  // OPEN   | jaw open, counting MOUTH_OPEN_FR frames
  typedef enum logic {CLOSED, OPEN} jaw_t;

  localparam int          WRAP        = H_ACTIVE + CROC_W;
  localparam logic [10:0] WRAP11      = 11'(WRAP);
  localparam logic [10:0] SPEED11     = 11'(SPEED);
  localparam logic [10:0] H_START11   = 11'(H_START);
  localparam logic [10:0] H_END11     = 11'(H_START + H_ACTIVE);
  localparam logic [10:0] CROC_W11    = 11'(CROC_W);
  localparam logic [10:0] HEAD_W11    = 11'(HEAD_W);
  localparam logic [10:0] LANE_Y11    = 11'(LANE_Y);
  localparam logic [10:0] LANE_END11  = 11'(LANE_Y + CROC_H);
  localparam logic [15:0] DIV_LAST    = 16'(FRAME_DIV - 1);
  localparam logic [15:0] CLOSED_LAST = 16'(MOUTH_CLOSED_FR - 1);
  localparam logic [15:0] OPEN_LAST   = 16'(MOUTH_OPEN_FR - 1);

  logic [9:0]  p;
  logic [15:0] div_cnt;
  logic [15:0] mcnt;
  jaw_t        state;

  logic        tick;
  logic [10:0] p11, hc11, vc11, edge_r, step_sum;
  logic [9:0]  p_next;
  logic        in_lane, in_vis, cov_h, head;

  assign tick   = (hc == 10'd0) && (vc == 10'(FRAME_LINE));
  assign p11    = {1'b0, p};
  assign hc11   = {1'b0, hc};
  assign vc11   = {1'b0, vc};
  // one column past the sprite's right edge, in hc coordinates
  assign edge_r = p11 + H_START11;

  always_comb begin
    step_sum = p11 + SPEED11;
    p_next   = p;
    if (DIR == 0) begin
      p_next = (step_sum >= WRAP11) ? 10'(step_sum - WRAP11) : 10'(step_sum);
    end else begin
      p_next = (p11 >= SPEED11) ? 10'(p11 - SPEED11) : 10'(p11 + WRAP11 - SPEED11);
    end
  end

  // offscreen parts of the sprite never render, so p=0 hides it completely
  assign in_lane = (vc11 >= LANE_Y11) && (vc11 < LANE_END11);
  assign in_vis  = (hc11 >= H_START11) && (hc11 < H_END11);
  assign cov_h   = (hc11 + CROC_W11 >= edge_r) && (hc11 < edge_r);
  assign head    = (DIR == 0) ? (hc11 + HEAD_W11 >= edge_r)
                              : (hc11 + CROC_W11 < edge_r + HEAD_W11);

  assign croc     = in_lane && in_vis && cov_h;
  assign croc_jaw = croc && head && mouth_open;
  assign croc_x   = p;

  always_ff @(posedge clk) begin
    if (reset) begin
      p          <= 10'(START_X);
      div_cnt    <= '0;
      mcnt       <= '0;
      state      <= CLOSED;
      mouth_open <= 1'b0;
    end else if (tick && !pause) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        p       <= p_next;
      end else begin
        div_cnt <= div_cnt + 16'd1;
      end
      case (state)
        CLOSED: begin
          if (mcnt == CLOSED_LAST) begin
            state      <= OPEN;
            mouth_open <= 1'b1;
            mcnt       <= '0;
          end else begin
            mcnt <= mcnt + 16'd1;
          end
        end
        OPEN: begin
          if (mcnt == OPEN_LAST) begin
            state      <= CLOSED;
            mouth_open <= 1'b0;
            mcnt       <= '0;
          end else begin
            mcnt <= mcnt + 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_croc_lane.sv
// Scoreboard bench for croc_lane: six differently configured lanes share one hc/vc/pause/reset stream
// and are checked against a closed-form model driven by the count of accepted frame ticks.
module tb_croc_lane;
  localparam int ND   = 6;
  localparam int WRAP = 736;
  localparam int SPD  [ND] = '{2, 2, 2, 5, 0, 0};
  localparam int DIRS [ND] = '{0, 0, 1, 1, 0, 1};
  localparam int SX   [ND] = '{0, 734, 1, 40, 96, 96};
  localparam int FDIV [ND] = '{1, 1, 1, 3, 1, 1};
  localparam int MC   [ND] = '{60, 60, 60, 5, 60, 60};
  localparam int MO   [ND] = '{30, 30, 30, 3, 30, 30};

  logic       clk = 1'b0;
  logic       reset, pause, probe;
  logic [9:0] hc, vc;
  logic       croc_o [ND];
  logic       jaw_o  [ND];
  logic       mo_o   [ND];
  logic [9:0] x_o    [ND];

  typedef struct {
    int d;
    int h;
    int v;
    bit croc;
    bit jaw;
    int x;
    bit mo;
  } exp_t;

  exp_t sbq[$];
  int   n = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  croc_lane #(.SPEED(2), .DIR(0), .START_X(0)) u0 (
    .clk(clk), .reset(reset), .hc(hc), .vc(vc), .pause(pause),
    .croc(croc_o[0]), .croc_jaw(jaw_o[0]), .croc_x(x_o[0]), .mouth_open(mo_o[0]));
  croc_lane #(.SPEED(2), .DIR(0), .START_X(734)) u1 (
    .clk(clk), .reset(reset), .hc(hc), .vc(vc), .pause(pause),
    .croc(croc_o[1]), .croc_jaw(jaw_o[1]), .croc_x(x_o[1]), .mouth_open(mo_o[1]));
  croc_lane #(.SPEED(2), .DIR(1), .START_X(1)) u2 (
    .clk(clk), .reset(reset), .hc(hc), .vc(vc), .pause(pause),
    .croc(croc_o[2]), .croc_jaw(jaw_o[2]), .croc_x(x_o[2]), .mouth_open(mo_o[2]));
  croc_lane #(.SPEED(5), .DIR(1), .START_X(40), .FRAME_DIV(3),
              .MOUTH_CLOSED_FR(5), .MOUTH_OPEN_FR(3)) u3 (
    .clk(clk), .reset(reset), .hc(hc), .vc(vc), .pause(pause),
    .croc(croc_o[3]), .croc_jaw(jaw_o[3]), .croc_x(x_o[3]), .mouth_open(mo_o[3]));
  croc_lane #(.SPEED(0), .DIR(0), .START_X(96)) u4 (
    .clk(clk), .reset(reset), .hc(hc), .vc(vc), .pause(pause),
    .croc(croc_o[4]), .croc_jaw(jaw_o[4]), .croc_x(x_o[4]), .mouth_open(mo_o[4]));
  croc_lane #(.SPEED(0), .DIR(1), .START_X(96)) u5 (
    .clk(clk), .reset(reset), .hc(hc), .vc(vc), .pause(pause),
    .croc(croc_o[5]), .croc_jaw(jaw_o[5]), .croc_x(x_o[5]), .mouth_open(mo_o[5]));

  // position after nt accepted ticks: one step every FDIV ticks, modulo the wrap length
  function automatic int exp_p(int d, int nt);
    int s;
    s = (nt / FDIV[d]) * SPD[d];
    if (DIRS[d] == 0) return (SX[d] + s) % WRAP;
    return ((SX[d] - s) % WRAP + WRAP) % WRAP;
  endfunction

  function automatic bit exp_open(int d, int nt);
    return (nt % (MC[d] + MO[d])) >= MC[d];
  endfunction

  function automatic bit exp_croc(int d, int nt, int h, int v);
    int p;
    p = exp_p(d, nt);
    return (v >= 200) && (v < 232) && (h >= 144) && (h < 784) &&
           (h >= p + 144 - 96) && (h <= p + 143);
  endfunction

  function automatic bit exp_jaw(int d, int nt, int h, int v);
    int p;
    bit hd;
    p  = exp_p(d, nt);
    hd = (DIRS[d] == 0) ? (h >= p + 144 - 32) : (h <= p + 144 - 96 + 31);
    return exp_croc(d, nt, h, v) && hd && exp_open(d, nt);
  endfunction

  task automatic drive(input int h, input int v, input bit pz, input bit rst, input bit pr);
    exp_t e;
    @(posedge clk);
    #1;
    hc = 10'(h); vc = 10'(v); pause = pz; reset = rst; probe = pr;
    if (pr) begin
      for (int d = 0; d < ND; d++) begin
        e.d = d; e.h = h; e.v = v;
        e.croc = exp_croc(d, n, h, v);
        e.jaw  = exp_jaw(d, n, h, v);
        e.x    = exp_p(d, n);
        e.mo   = exp_open(d, n);
        sbq.push_back(e);
      end
    end
    if (rst) n = 0;
    else if (h == 0 && v == 515 && !pz) n++;
  endtask

  task automatic tick(input bit pz);
    drive(0, 515, pz, 1'b0, 1'b0);
  endtask

  task automatic sweep(input int v, input int h0, input int h1);
    for (int h = h0; h <= h1; h++) drive(h, v, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic rand_probes(input int k);
    int d, p, h, v, sel;
    for (int i = 0; i < k; i++) begin
      d   = $urandom_range(ND - 1);
      p   = exp_p(d, n);
      sel = $urandom_range(11);
      case (sel)
        0: h = p + 142;
        1: h = p + 143;
        2: h = p + 144;
        3: h = p + 47;
        4: h = p + 48;
        5: h = p + 111;
        6: h = p + 112;
        7: h = p + 79;
        8: h = p + 80;
        9: h = 143 + $urandom_range(1);
        default: h = $urandom_range(799);
      endcase
      case ($urandom_range(6))
        0: v = 199;
        1: v = 200;
        2: v = 215;
        3: v = 231;
        4: v = 232;
        default: v = $urandom_range(514);
      endcase
      drive(h, v, 1'($urandom_range(1)), 1'b0, 1'b1);
    end
  endtask

  task automatic chk(input string name, input int d, input int h, input int v, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s u%0d hc=%0d vc=%0d n=%0d: got %0d expected %0d", name, d, h, v, n, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (probe === 1'b1) begin
        for (int d = 0; d < ND; d++) begin
          if (sbq.size() == 0) begin
            checks++; failures++;
            $display("FAIL scoreboard_underflow u%0d: got empty queue expected entry", d);
          end else begin
            e = sbq.pop_front();
            chk("croc",       e.d, e.h, e.v, int'(croc_o[e.d]), int'(e.croc));
            chk("croc_jaw",   e.d, e.h, e.v, int'(jaw_o[e.d]),  int'(e.jaw));
            chk("croc_x",     e.d, e.h, e.v, int'(x_o[e.d]),    e.x);
            chk("mouth_open", e.d, e.h, e.v, int'(mo_o[e.d]),   int'(e.mo));
          end
        end
      end
    end
  end

  initial begin : stim
    reset = 1'b1; pause = 1'b0; probe = 1'b0; hc = 10'd1; vc = 10'd0;
    drive(1, 0, 1'b0, 1'b1, 1'b0);
    drive(0, 515, 1'b0, 1'b1, 1'b1);
    sweep(200, 0, 799);
    sweep(215, 0, 799);
    repeat (20) begin tick(1'b0); rand_probes(4); end
    repeat (10) begin tick(1'b1); rand_probes(3); end
    while (n < 48) begin tick(1'b0); rand_probes(2); end
    sweep(200, 140, 245);
    sweep(232, 140, 245);
    sweep(199, 140, 245);
    while (n < 70) begin tick(1'b0); rand_probes(2); end
    sweep(200, 140, 245);
    sweep(231, 140, 245);
    while (n < 150) begin tick($urandom_range(4) == 0); rand_probes(2); end
    drive(150, 200, 1'b0, 1'b0, 1'b1);
    drive(0, 515, 1'b0, 1'b1, 1'b0);
    sweep(200, 140, 245);
    repeat (40) begin tick($urandom_range(3) == 0); rand_probes(3); end
    drive(1, 0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
